// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit.
package mult_div_unit_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_DIVU  = 2'b01,
    OP_MTHI  = 2'b10,
    OP_MTLO  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/md_addsub.sv
// Shared add/subtract used by the multiply add step and the divide trial subtract.
module md_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  logic [W-1:0] bOp;
  logic [W:0]   full;

  // Subtraction is a + ~b + 1; carry-out of 1 then means a >= b.
  always_comb begin
    bOp  = sub_i ? ~b_i : b_i;
    full = {1'b0, a_i} + {1'b0, bOp} + {{W{1'b0}}, sub_i};
  end

  assign sum_o  = full[W-1:0];
  assign cout_o = full[W];

endmodule

// File: rtl/mult_div_unit.sv
// Iterative unsigned MULTU/DIVU unit owning the HI/LO registers (also serves MTHI/MTLO).
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] DataA,
  input  logic [WIDTH-1:0] DataB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH:0]     r_q, r_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   dv_q, dv_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH:0]     addA, addB, addSum;
  logic               addSub, addCout;
  logic [WIDTH:0]     rShift, rStep;
  logic [WIDTH-1:0]   qStep;
  logic [2*WIDTH:0]   pStep;

  // The adder serves the multiply accumulate in MUL and the trial subtract in DIV.
  always_comb begin
    rShift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    addSub = (state_q == S_DIV);
    addA   = addSub ? rShift : {1'b0, p_q[2*WIDTH-1:WIDTH]};
    addB   = addSub ? {1'b0, dv_q} : {1'b0, m_q};
  end

  md_addsub #(.W(WIDTH + 1)) u_addsub (
    .a_i    (addA),
    .b_i    (addB),
    .sub_i  (addSub),
    .sum_o  (addSum),
    .cout_o (addCout)
  );

  always_comb begin
    pStep = p_q[0] ? ({addSum, p_q[WIDTH-1:0]} >> 1) : (p_q >> 1);
    rStep = addCout ? addSum : rShift;
    qStep = {q_q[WIDTH-2:0], addCout};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    m_d     = m_q;
    r_d     = r_q;
    q_d     = q_q;
    dv_d    = dv_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (Start) begin
          case (op_e'(Op))
            OP_MULTU: begin
              p_d     = {1'b0, {WIDTH{1'b0}}, DataB};
              m_d     = DataA;
              cnt_d   = '0;
              state_d = S_MUL;
            end
            OP_DIVU: begin
              r_d     = '0;
              q_d     = DataA;
              dv_d    = DataB;
              cnt_d   = '0;
              state_d = S_DIV;
            end
            OP_MTHI: hi_d = DataA;
            OP_MTLO: lo_d = DataA;
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_MUL: begin
        p_d = pStep;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          hi_d    = pStep[2*WIDTH-1:WIDTH];
          lo_d    = pStep[WIDTH-1:0];
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DIV: begin
        r_d = rStep;
        q_d = qStep;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          hi_d    = rStep[WIDTH-1:0];
          lo_d    = qStep;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      m_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
      dv_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      m_q     <= m_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dv_q    <= dv_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign Busy = (state_q == S_MUL) || (state_q == S_DIV);
  assign Done = (state_q == S_DONE);
  assign Hi   = hi_q;
  assign Lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: cycle-accurate Busy/Done/Hi/Lo model.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         Start;
  logic [1:0]   Op;
  logic [W-1:0] DataA, DataB;
  logic         Busy, Done;
  logic [W-1:0] Hi, Lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           doneCyc;
  } exp_t;

  exp_t         sbQ[$];
  exp_t         popped;
  logic         expDone;
  int           cyc = 0;
  int           busyFrom = 0;
  int           busyTo = -1;
  logic [W-1:0] modelHi = '0;
  logic [W-1:0] modelLo = '0;
  int           errors = 0;
  int           checks = 0;

  mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .Start (Start),
    .Op    (Op),
    .DataA (DataA),
    .DataB (DataB),
    .Busy  (Busy),
    .Done  (Done),
    .Hi    (Hi),
    .Lo    (Lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Called at a negedge; drives Start for one cycle and updates the model.
  task automatic applyStimulus(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [63:0] prod;
    Start = 1'b1;
    Op    = op;
    DataA = a;
    DataB = b;
    if (cyc > busyTo) begin
      case (op)
        OP_MULTU: begin
          prod  = {32'd0, a} * {32'd0, b};
          e.hi  = prod[63:32];
          e.lo  = prod[31:0];
        end
        OP_DIVU: begin
          e.hi = (b == 0) ? a : a % b;
          e.lo = (b == 0) ? '1 : a / b;
        end
        OP_MTHI: modelHi = a;
        default: modelLo = a;
      endcase
      if (op == OP_MULTU || op == OP_DIVU) begin
        e.doneCyc = cyc + W + 1;
        busyFrom  = cyc + 1;
        busyTo    = cyc + W;
        sbQ.push_back(e);
      end
    end
    @(negedge clk);
    Start = 1'b0;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 100 && cyc <= busyTo; i++) @(negedge clk);
    checkOutput("wait_idle_timeout", 64'(cyc > busyTo), 64'd1);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", 64'(Busy), 64'd0);
    checkOutput("rst_done", 64'(Done), 64'd0);
    checkOutput("rst_hi", 64'(Hi), 64'd0);
    checkOutput("rst_lo", 64'(Lo), 64'd0);
    sbQ.delete();
    busyFrom = 0;
    busyTo   = -1;
    modelHi  = '0;
    modelLo  = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Per-cycle monitor, sampled 1ns after the rising edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (rst_n) begin
      expDone = (sbQ.size() > 0) && (sbQ[0].doneCyc == cyc);
      checkOutput("busy", 64'(Busy), 64'(cyc >= busyFrom && cyc <= busyTo));
      checkOutput("done", 64'(Done), 64'(expDone));
      if (expDone) begin
        popped  = sbQ.pop_front();
        modelHi = popped.hi;
        modelLo = popped.lo;
      end
      checkOutput("hi", 64'(Hi), 64'(modelHi));
      checkOutput("lo", 64'(Lo), 64'(modelLo));
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog cycle=%0d got=running exp=finished", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    Start = 1'b0;
    Op    = 2'b00;
    DataA = '0;
    DataB = '0;
    @(negedge clk);
    doReset();
    repeat (2) @(negedge clk);

    applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitIdle();
    @(negedge clk);
    checkOutput("mul_max_hi", 64'(Hi), 64'h0000_0000_FFFF_FFFE);
    checkOutput("mul_max_lo", 64'(Lo), 64'h0000_0000_0000_0001);

    applyStimulus(OP_DIVU, 32'd100, 32'd7);
    waitIdle();
    @(negedge clk);
    checkOutput("div_100_7_lo", 64'(Lo), 64'd14);
    checkOutput("div_100_7_hi", 64'(Hi), 64'd2);

    applyStimulus(OP_DIVU, 32'd5, 32'd0);
    waitIdle();
    @(negedge clk);
    checkOutput("div_by0_lo", 64'(Lo), 64'h0000_0000_FFFF_FFFF);
    checkOutput("div_by0_hi", 64'(Hi), 64'd5);

    applyStimulus(OP_MULTU, 32'd3, 32'd4);
    @(negedge clk);
    applyStimulus(OP_DIVU, 32'd9, 32'd2);
    waitIdle();
    repeat (2) @(negedge clk);
    checkOutput("ignored_hi", 64'(Hi), 64'd0);
    checkOutput("ignored_lo", 64'(Lo), 64'd12);

    applyStimulus(OP_MTHI, 32'h1234, 32'd0);
    applyStimulus(OP_MTLO, 32'hABCD, 32'd0);
    @(negedge clk);
    checkOutput("mthi", 64'(Hi), 64'h1234);
    checkOutput("mtlo", 64'(Lo), 64'hABCD);

    applyStimulus(OP_MULTU, 32'd6, 32'd7);
    waitIdle();
    checkOutput("b2b_first_lo", 64'(Lo), 64'd42);
    applyStimulus(OP_DIVU, 32'd42, 32'd6);
    waitIdle();
    @(negedge clk);
    checkOutput("b2b_second_lo", 64'(Lo), 64'd7);
    checkOutput("b2b_second_hi", 64'(Hi), 64'd0);

    for (int i = 0; i < 6; i++) begin
      applyStimulus((i % 2 == 0) ? OP_MULTU : OP_DIVU, $urandom, (i == 5) ? $urandom_range(1, 300) : $urandom);
      waitIdle();
    end
    @(negedge clk);

    applyStimulus(OP_MULTU, 32'd1234567, 32'd7654321);
    repeat (9) @(negedge clk);
    doReset();
    repeat (40) @(negedge clk);

    for (int i = 0; i < 100 && sbQ.size() > 0; i++) @(negedge clk);
    checkOutput("scoreboard_drained", 64'(sbQ.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
